// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and sizing helper for the BCD converter.
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD = 4'd3;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  function automatic int digits_for_width(input int w);
    longint unsigned m;
    int d;
    m = (64'd1 << w) - 64'd1;
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (m >= 64'd10) begin
        m = m / 64'd10;
        d++;
      end
    end
    return d;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble digit cell, adds 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);
  assign adj = digit >= ADJ_THRESH ? digit + ADJ_ADD : digit;
endmodule

// File: rtl/bcd_conv_seq.sv
// bcd_conv_seq: sequential binary-to-BCD converter (double dabble), one bit per clock,
// with leading-zero blanking mask and overflow flag for the 7-segment drivers.
module bcd_conv_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]             blank,
  output logic                          ovf
);
  localparam int AW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [BIN_W-1:0] sreg;
  logic [AW-1:0] acc, adj, acc_nx;
  logic [DIGITS-1:0] blank_nx;
  logic sticky, sticky_nx, last, zero;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.digit(acc[4*i+:4]), .adj(adj[4*i+:4]));
  end
  assign acc_nx = {adj[AW-2:0], sreg[BIN_W-1]};
  assign sticky_nx = sticky | adj[AW-1];
  assign last = cnt == CW'(1);
  assign busy = state == ST_SHIFT;
  always_comb begin
    state_nx = state == ST_IDLE ? (start ? ST_SHIFT : ST_IDLE) : (last ? ST_IDLE : ST_SHIFT);
  end
  // blank runs from the top digit down until the first nonzero digit; digit 0 always shows
  always_comb begin
    blank_nx = '0;
    zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero = zero & (acc_nx[4*k+:4] == 4'd0);
      blank_nx[k] = zero;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sreg <= '0;
      acc <= '0;
      sticky <= 1'b0;
      bcd <= '0;
      blank <= BLANK_RST;
      ovf <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE && start) begin
        sreg <= bin;
        acc <= '0;
        sticky <= 1'b0;
        cnt <= CW'(BIN_W);
      end else if (busy) begin
        sreg <= sreg << 1;
        acc <= acc_nx;
        sticky <= sticky_nx;
        cnt <= cnt - 1'b1;
        if (last) begin
          bcd <= acc_nx;
          blank <= blank_nx;
          ovf <= sticky_nx;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_conv_seq.sv
// tb_bcd_conv_seq: three converter configurations checked every cycle against a decimal
// arithmetic model, plus hand-computed literal expectations.
module tb_bcd_conv_seq;
  import bcd_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int W[3] = '{16, 16, 8};
  int D[3] = '{5, 4, 3};
  logic [2:0] start = '0;
  logic [31:0] bn[3] = '{32'd0, 32'd0, 32'd0};
  logic busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic [19:0] bcd0;
  logic [15:0] bcd1;
  logic [11:0] bcd2;
  logic [4:0] blank0;
  logic [3:0] blank1;
  logic [2:0] blank2;

  bcd_conv_seq #(.BIN_W(16), .DIGITS(5)) u0 (.clk(clk), .rst_n(rst_n), .start(start[0]), .bin(bn[0][15:0]),
    .busy(busy0), .done(done0), .bcd(bcd0), .blank(blank0), .ovf(ovf0));
  bcd_conv_seq #(.BIN_W(16), .DIGITS(4)) u1 (.clk(clk), .rst_n(rst_n), .start(start[1]), .bin(bn[1][15:0]),
    .busy(busy1), .done(done1), .bcd(bcd1), .blank(blank1), .ovf(ovf1));
  bcd_conv_seq #(.BIN_W(8), .DIGITS(3)) u2 (.clk(clk), .rst_n(rst_n), .start(start[2]), .bin(bn[2][7:0]),
    .busy(busy2), .done(done2), .bcd(bcd2), .blank(blank2), .ovf(ovf2));

  logic a_busy[3], a_done[3], a_ovf[3];
  logic [19:0] a_bcd[3];
  logic [4:0] a_blank[3];
  always_comb begin
    a_busy = '{busy0, busy1, busy2};
    a_done = '{done0, done1, done2};
    a_ovf = '{ovf0, ovf1, ovf2};
    a_bcd = '{bcd0, 20'(bcd1), 20'(bcd2)};
    a_blank = '{blank0, 5'(blank1), 5'(blank2)};
  end

  int checks = 0;
  int passed = 0;
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d] got %h want %h at %0t", nm, i, act, exp, $time);
  endtask

  // decimal model: digits by repeated division, ovf if anything is left over
  function automatic void conv(input longint unsigned v, input int d, output logic [19:0] b,
                               output logic [4:0] bl, output logic o);
    logic nz;
    b = '0;
    bl = '0;
    nz = 1'b0;
    for (int k = 0; k < d; k++) begin
      b[4*k+:4] = 4'(v % 10);
      v = v / 10;
    end
    o = v != 0;
    for (int k = d - 1; k >= 1; k--) begin
      nz = nz | (b[4*k+:4] != 4'd0);
      bl[k] = !nz;
    end
  endfunction

  int m_cnt[3];
  longint unsigned m_val[3];
  logic m_done[3], m_ovf[3];
  logic [19:0] m_bcd[3];
  logic [4:0] m_blank[3];
  logic [19:0] t_bcd;
  logic [4:0] t_blank;
  logic t_ovf;
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_cnt[i] <= 0;
        m_val[i] <= 0;
        m_done[i] <= 1'b0;
        m_bcd[i] <= '0;
        m_blank[i] <= 5'((1 << D[i]) - 2);
        m_ovf[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_cnt[i] == 0) begin
          if (start[i]) begin
            m_val[i] <= longint'(bn[i]) & ((64'd1 << W[i]) - 64'd1);
            m_cnt[i] <= W[i];
          end
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            conv(m_val[i], D[i], t_bcd, t_blank, t_ovf);
            m_bcd[i] <= t_bcd;
            m_blank[i] <= t_blank;
            m_ovf[i] <= t_ovf;
            m_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  int dcnt[3] = '{0, 0, 0};
  int bcnt[3] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("busy", i, 32'(a_busy[i]), 32'(m_cnt[i] != 0));
      chk("done", i, 32'(a_done[i]), 32'(m_done[i]));
      chk("bcd", i, 32'(a_bcd[i]), 32'(m_bcd[i]));
      chk("blank", i, 32'(a_blank[i]), 32'(m_blank[i]));
      chk("ovf", i, 32'(a_ovf[i]), 32'(m_ovf[i]));
      if (a_done[i]) dcnt[i]++;
      if (a_busy[i]) bcnt[i]++;
    end
  end

  task automatic go(input int i, input logic [31:0] v);
    @(negedge clk);
    bn[i] = v;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (a_done[i]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", i, 32'(seen), 32'd1);
  endtask

  logic [19:0] p_bcd;
  logic [4:0] p_blank;
  logic p_ovf;
  int b0;
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 0, 32'(busy0), 32'd0);
    chk("rst_done", 0, 32'(done0), 32'd0);
    chk("rst_bcd", 0, 32'(bcd0), 32'd0);
    chk("rst_blank", 0, 32'(blank0), 32'b11110);
    chk("rst_blank", 2, 32'(blank2), 32'b110);
    rst_n = 1'b1;
    chk("digits_for_width16", 0, 32'(digits_for_width(16)), 32'd5);
    chk("digits_for_width8", 0, 32'(digits_for_width(8)), 32'd3);
    conv(12345, 4, p_bcd, p_blank, p_ovf);
    chk("model_bcd", 1, 32'(p_bcd), 32'h2345);
    chk("model_ovf", 1, 32'(p_ovf), 32'd1);
    conv(7, 3, p_bcd, p_blank, p_ovf);
    chk("model_bcd", 2, 32'(p_bcd), 32'h007);
    chk("model_blank", 2, 32'(p_blank), 32'b110);

    go(0, 0);
    wait_done(0, 20);
    @(negedge clk);
    #1;
    chk("zero_bcd", 0, 32'(bcd0), 32'h00000);
    chk("zero_blank", 0, 32'(blank0), 32'b11110);
    chk("zero_ovf", 0, 32'(ovf0), 32'd0);
    chk("zero_dones", 0, 32'(dcnt[0]), 32'd1);

    b0 = bcnt[0];
    @(negedge clk);
    bn[0] = 65535;
    bn[1] = 12345;
    start = 3'b011;
    @(negedge clk);
    start = 3'b000;
    wait_done(0, 20);
    @(negedge clk);
    #1;
    chk("max_bcd", 0, 32'(bcd0), 32'h65535);
    chk("max_blank", 0, 32'(blank0), 32'b00000);
    chk("max_ovf", 0, 32'(ovf0), 32'd0);
    chk("max_busy_cycles", 0, 32'(bcnt[0] - b0), 32'd16);
    chk("trunc_bcd", 1, 32'(bcd1), 32'h2345);
    chk("trunc_ovf", 1, 32'(ovf1), 32'd1);
    chk("trunc_blank", 1, 32'(blank1), 32'b0000);

    for (int v = 0; v < 256; v++) begin
      bn[2] = 32'(v);
      start[2] = 1'b1;
      @(negedge clk);
      wait_done(2, 12);
    end
    start[2] = 1'b0;
    @(negedge clk);
    #1;
    chk("exh_last_bcd", 2, 32'(bcd2), 32'h255);
    chk("exh_last_blank", 2, 32'(blank2), 32'b000);
    chk("exh_dones", 2, 32'(dcnt[2]), 32'd256);

    go(0, 1234);
    repeat (2) @(negedge clk);
    bn[0] = 9999;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 20);
    repeat (3) @(negedge clk);
    #1;
    chk("ign_bcd", 0, 32'(bcd0), 32'h01234);
    chk("ign_blank", 0, 32'(blank0), 32'b10000);
    chk("ign_dones", 0, 32'(dcnt[0]), 32'd3);

    go(0, 4321);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 0, 32'(busy0), 32'd0);
    chk("abort_done", 0, 32'(done0), 32'd0);
    chk("abort_bcd", 0, 32'(bcd0), 32'd0);
    chk("abort_blank", 0, 32'(blank0), 32'b11110);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("abort_dones", 0, 32'(dcnt[0]), 32'd3);
    go(0, 9876);
    wait_done(0, 20);
    @(negedge clk);
    #1;
    chk("post_rst_bcd", 0, 32'(bcd0), 32'h09876);
    chk("post_rst_blank", 0, 32'(blank0), 32'b10000);
    chk("post_rst_dones", 0, 32'(dcnt[0]), 32'd4);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
